passcode_entry: RTL
===================

# passcode_entry

Front-end capture stage for the passcode blinker. Debounces two push-buttons, collects four 5-bit symbols from the slide switches one per confirmed Enter press, and presents them as a held, parallel four-symbol frame with a valid/ack handshake. The LED long/short pulse transmitter consumes the frame: `code0..code3` feed its four 5-bit symbol inputs, MSB sent first. The transmitter returns `code_ack` when it has finished sending the frame.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000 (10 ms at 100 MHz): number of consecutive identical synchronized samples required to accept a button level change. Legal range is ≥2.
- `CNT_W`, default 20: width of the debounce counter. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  system clock. All logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sw`  in  5  raw slide-switch symbol, sampled at capture. Quasi-static, so it gets no synchronizer.
- `btn_enter`  in  1  raw, bouncing Enter button. Active-high.
- `btn_clear`  in  1  raw, bouncing Clear button. Active-high.
- `code_ack`  in  1  one-cycle pulse from the transmitter: frame consumed.
- `code0`, `code1`, `code2`, `code3`  out  5 each  captured symbols, in entry order.
- `code_valid`  out  1  frame complete and held stable.
- `slot_count`  out  3  number of symbols captured so far, 0..4.

## Operation

Per button (Enter and Clear are handled identically):
- A 2-flop synchronizer feeds a debounce counter.
- While the synchronized level differs from the accepted level, the counter increments. Any cycle where they match clears the counter.
- When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the accepted level takes the synchronized value and the counter clears.
- A one-cycle `*_pulse` is registered on each 0→1 transition of the accepted level. Releases produce nothing.

State machine, two states: COLLECT (reset state) and FULL.

COLLECT:
- `enter_pulse` writes `sw` into slot `slot_count` and increments `slot_count`.
- The write that makes `slot_count`=4 moves to FULL on the same edge.
- `clear_pulse` zeroes all codes and sets `slot_count` to 0.
- If `clear_pulse` and `enter_pulse` arrive in the same cycle, clear wins and no capture occurs.
- `code_ack` is ignored.

FULL:
- `code_valid`=1. `code0..3` and `slot_count`=4 are held constant.
- `enter_pulse` and `clear_pulse` are ignored, because the transmitter is mid-frame.
- `code_ack` returns to COLLECT with `slot_count`=0. The codes keep their old values until they are overwritten.
- If `code_ack` and `enter_pulse` arrive in the same cycle, the ack is taken and the enter is dropped.

Widths and limits:
- `slot_count` never exceeds 4 and never wraps.
- The slot index uses `slot_count`[1:0], and only while in COLLECT.

## Timing

Reset values (asynchronous `rst`):
- All codes = 0, `slot_count` = 0, `code_valid` = 0, state = COLLECT.
- Synchronizers, accepted levels and counters are all 0.
- A reset in mid-debounce or mid-frame discards everything. There is no partial frame recovery.

Latencies:
- A raw level held clean from cycle 0 is synchronized by cycle 2. The accepted level updates at cycle 2+DEBOUNCE_CYCLES, and the pulse is high during cycle 3+DEBOUNCE_CYCLES.
- A capture is visible on the outputs one cycle after the pulse cycle.
- `code_valid` rises on the same edge as the fourth capture.
- `code_valid` falls on the edge that samples `code_ack`=1. It is guaranteed low from the next cycle.

Filtering:
- A bounce shorter than DEBOUNCE_CYCLES resets the counter and produces no pulse.
- A held button produces exactly one pulse.

Handshake rule: `code0..3` must not change while `code_valid`=1.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

- **Reset:** assert `rst` mid-run → all outputs 0 immediately (asynchronously), and they stay 0 for 5 cycles after release with idle buttons.
- **Bounce rejection:** toggle `btn_enter` 1,0,1,0 with 2-cycle widths, then hold it high for 10 cycles with `sw`=5'b10110 → exactly one capture, `code0`=10110, `slot_count`=1, capture visible 8 cycles after the hold begins.
- **Full frame:** four clean presses with `sw` = 5'h01, 5'h1F, 5'h0A, 5'h15 → `code0..3` = 01, 1F, 0A, 15 and `code_valid`=1. A fifth press leaves everything unchanged.
- **Ack:** pulse `code_ack` for one cycle while FULL → `code_valid` 0 the next cycle, `slot_count`=0. A new press with `sw`=5'h03 writes `code0`=03, and `code1..3` retain 1F, 0A, 15.
- **Clear:** press Enter twice, then press Clear → `slot_count`=0 and all codes 0. Clear while FULL → no change, `code_valid` stays 1.
- **Simultaneous events:**
  - Enter and Clear pulses in the same cycle with `slot_count`=2 → `slot_count`=0, no capture.
  - Ack and Enter pulse in the same cycle → COLLECT with `slot_count`=0.

Source files
------------

// File: rtl/passcode_entry.sv
// ---------------------------------------------------------------------------
// passcode_entry
//   Front-end capture stage for the passcode blinker. Two bouncing push
//   buttons (Enter, Clear) are synchronized and debounced. Each confirmed
//   Enter press latches the slide-switch symbol into the next of four slots.
//   Once four symbols are held, the frame is presented with code_valid until
//   the LED transmitter acknowledges it with code_ack.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   sw[4:0]     raw slide-switch symbol (quasi-static, unsynchronized)
//   btn_enter   raw Enter button, active high
//   btn_clear   raw Clear button, active high
//   code_ack    one-cycle pulse: transmitter finished the frame
//   code0..3    captured symbols in entry order
//   code_valid  frame complete; codes held stable while high
//   slot_count  symbols captured so far, 0..4
// ---------------------------------------------------------------------------

// Per-button synchronizer + debouncer + rising-edge pulse.
module passcode_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;   // sync[1] is the synchronized level
  logic             acc;    // accepted (debounced) level
  logic             acc_d;  // accepted level one cycle ago, for edge detect
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      acc   <= 1'b0;
      acc_d <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      acc_d <= acc;
      // Registered press pulse: one cycle after the accepted level rises.
      pulse <= acc & ~acc_d;
      if (sync[1] != acc) begin
        // Level has been different for DEBOUNCE_CYCLES samples: accept it.
        if (cnt == CNT_LAST) begin
          acc <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // Any agreeing sample restarts the qualification window.
        cnt <= '0;
      end
    end
  end
endmodule

module passcode_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic       code_ack,
  output logic [4:0] code0,
  output logic [4:0] code1,
  output logic [4:0] code2,
  output logic [4:0] code3,
  output logic       code_valid,
  output logic [2:0] slot_count
);
  localparam int NUM_BTN = 2;
  localparam int BTN_ENT = 0;
  localparam int BTN_CLR = 1;

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_pulse;
  logic               enter_pulse;
  logic               clear_pulse;

  state_t             state;
  logic [3:0][4:0]    codes;

  assign btn_raw = {btn_clear, btn_enter};

  // Both buttons get identical conditioning.
  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      passcode_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_db (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_raw[g]),
        .pulse(btn_pulse[g])
      );
    end
  endgenerate

  assign enter_pulse = btn_pulse[BTN_ENT];
  assign clear_pulse = btn_pulse[BTN_CLR];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      codes      <= '0;
      slot_count <= 3'd0;
      code_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          // Clear has priority over a coincident Enter.
          if (clear_pulse) begin
            codes      <= '0;
            slot_count <= 3'd0;
          end else if (enter_pulse) begin
            codes[slot_count[1:0]] <= sw;
            slot_count             <= slot_count + 3'd1;
            // Fourth capture completes the frame on the same edge.
            if (slot_count == 3'd3) begin
              state      <= FULL;
              code_valid <= 1'b1;
            end
          end
        end
        FULL: begin
          // Frame is frozen while the transmitter works; buttons ignored.
          // Codes are left as-is after ack and get overwritten slot by slot.
          if (code_ack) begin
            state      <= COLLECT;
            slot_count <= 3'd0;
            code_valid <= 1'b0;
          end
        end
        default: begin
          state      <= COLLECT;
          code_valid <= 1'b0;
        end
      endcase
    end
  end

  assign code0 = codes[0];
  assign code1 = codes[1];
  assign code2 = codes[2];
  assign code3 = codes[3];
endmodule
